// File: rtl/incubator_pkg.sv
// Shared definitions for the incubator climate controller: state encodings
// (also driven out on the mode port) and a small state-classification helper.
package incubator_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_HEAT     = 3'd1;
    localparam state_t ST_COOL_LO  = 3'd2;
    localparam state_t ST_COOL_MID = 3'd3;
    localparam state_t ST_COOL_HI  = 3'd4;

    // True for any of the three cooling levels.
    function automatic logic is_cooling(input state_t s);
        return (s == ST_COOL_LO) || (s == ST_COOL_MID) || (s == ST_COOL_HI);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Minimum-dwell timer: counts cycles since the last state change and reports
// when the hold time has elapsed. With MIN_DWELL=0 the counter is a single bit
// that never leaves zero, so done is permanently asserted.
module dwell_timer #(
    parameter int MIN_DWELL = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic done
);

    localparam int CNT_W = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_DWELL);

    logic [CNT_W-1:0] count;

    // Restart from zero on a state change, otherwise count up and saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CNT_MAX);

endmodule

// File: rtl/incubator_ctrl_pro.sv
// Incubator climate controller top: five-state hysteresis FSM driving heater,
// cooler and cooler speed code from a signed, qualified temperature sample.
// A minimum-dwell timer blocks state changes until the current state has been
// held long enough. Optional sticky out-of-range alarm enabled by defining
// INCUBATOR_ALARM_EN; without it alarm is tied low and alarm_clr is ignored.
module incubator_ctrl_pro
    import incubator_pkg::*;
#(
    parameter int TEMP_W    = 8,
    parameter int CRS_W     = 4,
    parameter int HEAT_ON   = 15,
    parameter int HEAT_OFF  = 30,
    parameter int COOL_ON   = 35,
    parameter int COOL_OFF  = 25,
    parameter int LO_UP     = 40,
    parameter int MID_UP    = 45,
    parameter int MID_DN    = 35,
    parameter int HI_DN     = 40,
    parameter int CRS_LO    = 4,
    parameter int CRS_MID   = 6,
    parameter int CRS_HI    = 8,
    parameter int MIN_DWELL = 0,
    parameter int ALARM_HI  = 50,
    parameter int ALARM_LO  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [TEMP_W-1:0] temperature,
    input  logic                     temp_valid,
    input  logic                     alarm_clr,
    output logic                     heater,
    output logic                     cooler,
    output logic [CRS_W-1:0]         crs,
    output logic [2:0]               mode,
    output logic                     alarm
);

    // Thresholds narrowed to the sample width so every compare is TEMP_W-wide signed.
    localparam logic signed [TEMP_W-1:0] T_HEAT_ON  = TEMP_W'(HEAT_ON);
    localparam logic signed [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(HEAT_OFF);
    localparam logic signed [TEMP_W-1:0] T_COOL_ON  = TEMP_W'(COOL_ON);
    localparam logic signed [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(COOL_OFF);
    localparam logic signed [TEMP_W-1:0] T_LO_UP    = TEMP_W'(LO_UP);
    localparam logic signed [TEMP_W-1:0] T_MID_UP   = TEMP_W'(MID_UP);
    localparam logic signed [TEMP_W-1:0] T_MID_DN   = TEMP_W'(MID_DN);
    localparam logic signed [TEMP_W-1:0] T_HI_DN    = TEMP_W'(HI_DN);

    state_t           state;
    state_t           state_nxt;
    logic             dwell_done;
    logic             restart;
    logic [CRS_W-1:0] crs_nxt;

    assign restart = (state_nxt != state);

    dwell_timer #(
        .MIN_DWELL(MIN_DWELL)
    ) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .done   (dwell_done)
    );

    // Next-state logic: one step per qualified sample, first matching condition wins.
    always_comb begin
        state_nxt = state;
        if (temp_valid && dwell_done) begin
            case (state)
                ST_IDLE: begin
                    if (temperature < T_HEAT_ON)
                        state_nxt = ST_HEAT;
                    else if (temperature > T_COOL_ON)
                        state_nxt = ST_COOL_LO;
                end
                ST_HEAT: begin
                    if (temperature > T_HEAT_OFF)
                        state_nxt = ST_IDLE;
                end
                ST_COOL_LO: begin
                    if (temperature < T_COOL_OFF)
                        state_nxt = ST_IDLE;
                    else if (temperature > T_LO_UP)
                        state_nxt = ST_COOL_MID;
                end
                ST_COOL_MID: begin
                    if (temperature > T_MID_UP)
                        state_nxt = ST_COOL_HI;
                    else if (temperature < T_MID_DN)
                        state_nxt = ST_COOL_LO;
                end
                ST_COOL_HI: begin
                    if (temperature < T_HI_DN)
                        state_nxt = ST_COOL_MID;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Speed code for the upcoming state; zero whenever the cooler is off.
    always_comb begin
        crs_nxt = '0;
        case (state_nxt)
            ST_COOL_LO:  crs_nxt = CRS_W'(CRS_LO);
            ST_COOL_MID: crs_nxt = CRS_W'(CRS_MID);
            ST_COOL_HI:  crs_nxt = CRS_W'(CRS_HI);
            default:     crs_nxt = '0;
        endcase
    end

    // State register and outputs decoded from the next state, so they move on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            heater <= 1'b0;
            cooler <= 1'b0;
            crs    <= '0;
        end else begin
            state  <= state_nxt;
            heater <= (state_nxt == ST_HEAT);
            cooler <= is_cooling(state_nxt);
            crs    <= crs_nxt;
        end
    end

    assign mode = state;

`ifdef INCUBATOR_ALARM_EN
    localparam logic signed [TEMP_W-1:0] T_ALARM_HI = TEMP_W'(ALARM_HI);
    localparam logic signed [TEMP_W-1:0] T_ALARM_LO = TEMP_W'(ALARM_LO);

    logic alarm_q;

    // Sticky alarm: an out-of-range sample sets it and beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_q <= 1'b0;
        end else if (temp_valid && ((temperature >= T_ALARM_HI) || (temperature <= T_ALARM_LO))) begin
            alarm_q <= 1'b1;
        end else if (alarm_clr) begin
            alarm_q <= 1'b0;
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_alarm_cfg;

    assign unused_alarm_cfg = &{1'b0, alarm_clr, ALARM_HI[0], ALARM_LO[0]};
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_incubator_ctrl_pro.sv
// Testbench for incubator_ctrl_pro: table-driven vectors against a zero-dwell
// instance, plus hand-written sequences for minimum dwell (second instance with
// MIN_DWELL=3) and asynchronous reset while cooling at full speed.
module tb_incubator_ctrl_pro;

`ifdef INCUBATOR_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic signed [7:0] temperature;
    logic              temp_valid;
    logic              alarm_clr;

    logic       heater0, cooler0, alarm0;
    logic [3:0] crs0;
    logic [2:0] mode0;
    logic       heater3, cooler3, alarm3;
    logic [3:0] crs3;
    logic [2:0] mode3;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int temp;
        bit valid;
        bit clr;
        bit heater;
        bit cooler;
        int crs;
        int mode;
        bit alarm;
    } vec_t;

    vec_t vecs[$];

    incubator_ctrl_pro #(.MIN_DWELL(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .temperature(temperature),
        .temp_valid (temp_valid),
        .alarm_clr  (alarm_clr),
        .heater     (heater0),
        .cooler     (cooler0),
        .crs        (crs0),
        .mode       (mode0),
        .alarm      (alarm0)
    );

    incubator_ctrl_pro #(.MIN_DWELL(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .temperature(temperature),
        .temp_valid (temp_valid),
        .alarm_clr  (alarm_clr),
        .heater     (heater3),
        .cooler     (cooler3),
        .crs        (crs3),
        .mode       (mode3),
        .alarm      (alarm3)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check1(input string name, input int act, input int exp);
        checks++;
        if (act == exp)
            passes++;
        else
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic checkOutput(input string tag, input bit h, input bit c,
                               input int cr, input int m, input bit a);
        check1({tag, " heater"}, int'(heater0), int'(h));
        check1({tag, " cooler"}, int'(cooler0), int'(c));
        check1({tag, " crs"},    int'(crs0),    cr);
        check1({tag, " mode"},   int'(mode0),   m);
        check1({tag, " alarm"},  int'(alarm0),  int'(a & ALARM_ON));
    endtask

    task automatic applyStimulus(input int t, input bit v, input bit c);
        @(negedge clk);
        temperature = 8'(t);
        temp_valid  = v;
        alarm_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input int t, input bit v, input bit c, input bit h,
                          input bit co, input int cr, input int m, input bit a);
        vec_t e;
        e.temp = t; e.valid = v; e.clr = c; e.heater = h;
        e.cooler = co; e.crs = cr; e.mode = m; e.alarm = a;
        vecs.push_back(e);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        temperature = '0;
        temp_valid  = 1'b0;
        alarm_clr   = 1'b0;

        //      temp valid clr  heat cool crs mode alarm
        addVec(  20, 1, 0,   0, 0, 0, 0, 0);
        addVec(  10, 1, 0,   1, 0, 0, 1, 0);
        addVec(  30, 1, 0,   1, 0, 0, 1, 0);
        addVec(  31, 1, 0,   0, 0, 0, 0, 0);
        addVec(  36, 1, 0,   0, 1, 4, 2, 0);
        addVec(  41, 1, 0,   0, 1, 6, 3, 0);
        addVec(  46, 1, 0,   0, 1, 8, 4, 0);
        addVec(  39, 1, 0,   0, 1, 6, 3, 0);
        addVec(  34, 1, 0,   0, 1, 4, 2, 0);
        addVec(  24, 1, 0,   0, 0, 0, 0, 0);
        addVec(  15, 1, 0,   0, 0, 0, 0, 0);
        addVec(  35, 1, 0,   0, 0, 0, 0, 0);
        addVec(-100, 0, 0,   0, 0, 0, 0, 0);
        addVec(-100, 1, 0,   1, 0, 0, 1, 1);
        addVec(  31, 1, 0,   0, 0, 0, 0, 1);
        addVec(  20, 1, 1,   0, 0, 0, 0, 0);
        addVec(  36, 1, 0,   0, 1, 4, 2, 0);
        addVec(  41, 1, 0,   0, 1, 6, 3, 0);
        addVec(  46, 1, 0,   0, 1, 8, 4, 0);
        addVec(  20, 1, 0,   0, 1, 6, 3, 0);
        addVec(  20, 1, 0,   0, 1, 4, 2, 0);
        addVec(  20, 1, 0,   0, 0, 0, 0, 0);
        addVec(  10, 1, 0,   1, 0, 0, 1, 0);
        addVec(  50, 1, 0,   0, 0, 0, 0, 1);
        addVec(  55, 1, 1,   0, 1, 4, 2, 1);
        addVec(  20, 1, 1,   0, 0, 0, 0, 0);
        addVec(  36, 1, 0,   0, 1, 4, 2, 0);
        addVec(  10, 0, 0,   0, 1, 4, 2, 0);
        addVec(  24, 1, 0,   0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 0, 0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].temp, vecs[i].valid, vecs[i].clr);
            checkOutput($sformatf("row%0d", i), vecs[i].heater, vecs[i].cooler,
                        vecs[i].crs, vecs[i].mode, vecs[i].alarm);
        end

        // Minimum dwell on the MIN_DWELL=3 instance: let IDLE dwell expire first.
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(36, 1'b1, 1'b0);
        check1("dwell enter lo mode", int'(mode3), 2);
        check1("dwell enter lo crs",  int'(crs3),  4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(41, 1'b1, 1'b0);
            check1($sformatf("dwell hold%0d mode", i), int'(mode3), 2);
            check1($sformatf("dwell hold%0d crs", i),  int'(crs3),  4);
        end
        applyStimulus(41, 1'b1, 1'b0);
        check1("dwell release mode", int'(mode3), 3);
        check1("dwell release crs",  int'(crs3),  6);

        // Asynchronous reset while at full cooling, checked before the next clock edge.
        doReset();
        applyStimulus(36, 1'b1, 1'b0);
        applyStimulus(41, 1'b1, 1'b0);
        applyStimulus(46, 1'b1, 1'b0);
        checkOutput("pre-reset hi", 1'b0, 1'b1, 8, 4, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset", 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
